// File: rtl/sipo_deserializer_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
package sipo_deserializer_pkg;

  // Frame assembly state: IDLE holds no partial word, COLLECT holds 1..WIDTH-1 bits.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Matches the downstream 4-bit PIPO register.
  localparam int DEFAULT_WIDTH = 4;

  // Width of the bit counter. It never reaches WIDTH because a full word wraps to 0.
  // The result is never below 1, so the counter port is never zero width.
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// Output holding register with a valid/ready handshake.
// If a consume and a load land on the same edge, the new word replaces the old one.
// A load while an unconsumed word is held is dropped and reported on drop.
module sipo_hold_reg
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             drop
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             consume;

  // Decide the next word and valid flag from load and consume.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    consume = valid_q & ready;
    drop    = 1'b0;
    if (load && (!valid_q || consume)) begin
      data_d  = din;
      valid_d = 1'b1;
    end else if (load) begin
      drop    = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state. data is kept after consume, so the downstream sees a stable bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer. It assembles WIDTH-bit words from a gated serial
// stream and hands them to a holding register. Progress, busy and a sticky overrun flag
// are reported. Every output comes from a flop.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int  WIDTH     = DEFAULT_WIDTH,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int CW        = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             busy,
  output logic             overrun
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d, state_eff;
  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_eff, shifted;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_eff;
  logic             ovr_q, ovr_d;
  logic             done, drop;

  // Shift and count. Sync first rewinds to an empty frame, so a bit arriving with sync
  // becomes bit 1 of the new frame.
  always_comb begin
    state_eff = sync ? IDLE : state_q;
    shreg_eff = sync ? '0   : shreg_q;
    cnt_eff   = sync ? '0   : cnt_q;
    if (MSB_FIRST) shifted = {shreg_eff[WIDTH-2:0], sin};
    else           shifted = {sin, shreg_eff[WIDTH-1:1]};

    state_d = state_eff;
    shreg_d = shreg_eff;
    cnt_d   = cnt_eff;
    done    = 1'b0;
    if (sin_valid) begin
      unique case (state_eff)
        IDLE: begin
          state_d = COLLECT;
          shreg_d = shifted;
          cnt_d   = CW'(1);
        end
        COLLECT: begin
          if (cnt_eff == LAST) begin
            done    = 1'b1;
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
          end else begin
            shreg_d = shifted;
            cnt_d   = cnt_eff + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The overrun flag is sticky. Only sync or reset clears it.
  always_comb begin
    ovr_d = sync ? 1'b0 : (ovr_q | drop);
  end

  // Registers for the frame state, the shift register, the counter and the overrun flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  // The completed word is the bit accepted on this edge merged with the bits already held.
  sipo_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .rst_n (reset),
    .load  (done),
    .din   (shifted),
    .ready (par_ready),
    .dout  (par_out),
    .valid (par_valid),
    .drop  (drop)
  );

  assign bit_cnt = cnt_q;
  assign busy    = (state_q == COLLECT);
  assign overrun = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer. Two instances (MSB-first and LSB-first) take the same
// stimulus. A frame-level model predicts every output. Directed scenarios use literal
// expectations, and a randomized phase follows them.
module tb_sipo_deserializer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sin = 1'b0, sin_valid = 1'b0, sync = 1'b0, par_ready = 1'b0;
  logic       chk_en = 1'b0;
  int         errors = 0, checks = 0;

  logic [3:0] po [2];
  logic       pv [2];
  logic [1:0] bc [2];
  logic       bz [2];
  logic       ov [2];

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .par_out(po[0]), .par_valid(pv[0]), .par_ready(par_ready),
    .bit_cnt(bc[0]), .busy(bz[0]), .overrun(ov[0]));

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .par_out(po[1]), .par_valid(pv[1]), .par_ready(par_ready),
    .bit_cnt(bc[1]), .busy(bz[1]), .overrun(ov[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state. The frame is kept as the bits in arrival order plus a count. The word
  // is built from positions only when the frame completes.
  logic [3:0] m_ord [2];
  int         m_cnt [2];
  logic [3:0] m_hw  [2];
  logic       m_hv  [2];
  logic       m_ov  [2];

  function automatic logic [3:0] form(input logic [3:0] ord, input bit msb);
    logic [3:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (msb) w[3-i] = ord[i];
      else     w[i]   = ord[i];
    end
    return w;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        m_ord[m] <= '0; m_cnt[m] <= 0; m_hw[m] <= '0; m_hv[m] <= 1'b0; m_ov[m] <= 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        logic [3:0] o;
        logic [3:0] w;
        int         c;
        logic       done;
        logic       drop;
        o = m_ord[m]; c = m_cnt[m]; done = 1'b0; drop = 1'b0; w = '0;
        if (sync) begin o = '0; c = 0; end
        if (sin_valid) begin
          o[c] = sin;
          c = c + 1;
          if (c == 4) begin done = 1'b1; w = form(o, m == 0); c = 0; o = '0; end
        end
        m_ord[m] <= o;
        m_cnt[m] <= c;
        if (done && (!m_hv[m] || par_ready)) begin
          m_hw[m] <= w; m_hv[m] <= 1'b1;
        end else if (done) begin
          drop = 1'b1;
        end else if (m_hv[m] && par_ready) begin
          m_hv[m] <= 1'b0;
        end
        m_ov[m] <= sync ? 1'b0 : (m_ov[m] | drop);
      end
    end
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        string s;
        s = (m == 0) ? "msb" : "lsb";
        chk({s, ".par_out"},   32'(po[m]), 32'(m_hw[m]));
        chk({s, ".par_valid"}, 32'(pv[m]), 32'(m_hv[m]));
        chk({s, ".bit_cnt"},   32'(bc[m]), 32'(m_cnt[m]));
        chk({s, ".busy"},      32'(bz[m]), 32'(m_cnt[m] != 0));
        chk({s, ".overrun"},   32'(ov[m]), 32'(m_ov[m]));
      end
    end
  end

  task automatic cyc(input logic v, input logic s, input logic sy, input logic rdy);
    sin_valid = v; sin = s; sync = sy; par_ready = rdy;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] pat;
    // Reset, then idle.
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; chk_en = 1'b1;
    for (int m = 0; m < 2; m++) begin
      chk("rst.par_out", 32'(po[m]), 32'h0);
      chk("rst.par_valid", 32'(pv[m]), 32'h0);
      chk("rst.bit_cnt", 32'(bc[m]), 32'h0);
      chk("rst.busy", 32'(bz[m]), 32'h0);
      chk("rst.overrun", 32'(ov[m]), 32'h0);
    end

    // Back-to-back bits 1,0,1,1 with ready high.
    cyc(1, 1, 0, 1); chk("s1.cnt1", 32'(bc[0]), 32'd1);
    cyc(1, 0, 0, 1); chk("s1.cnt2", 32'(bc[0]), 32'd2);
    cyc(1, 1, 0, 1); chk("s1.cnt3", 32'(bc[0]), 32'd3); chk("s1.pv_early", 32'(pv[0]), 32'd0);
    cyc(1, 1, 0, 1); chk("s1.cnt0", 32'(bc[0]), 32'd0);
    chk("s1.pv", 32'(pv[0]), 32'd1);
    chk("s1.msb_word", 32'(po[0]), 32'hB);
    chk("s1.lsb_word", 32'(po[1]), 32'hD);
    cyc(0, 0, 0, 1); chk("s1.pv_after", 32'(pv[0]), 32'd0);

    // Bits 1,1,0,0 separated by 3-cycle gaps.
    pat = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      cyc(1, pat[i], 0, 1);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          cyc(0, 0, 0, 1);
          chk("s2.busy_gap", 32'(bz[1]), 32'd1);
          chk("s2.cnt_gap", 32'(bc[1]), 32'(i + 1));
        end
      end
    end
    chk("s2.lsb_word", 32'(po[1]), 32'h3);
    chk("s2.msb_word", 32'(po[0]), 32'hC);
    cyc(0, 0, 0, 1);

    // Overrun with ready held low.
    pat = 4'b1100;
    for (int i = 3; i >= 0; i--) cyc(1, pat[i], 0, 0);
    chk("s3.pv", 32'(pv[0]), 32'd1);
    pat = 4'b0101;
    for (int i = 3; i >= 0; i--) cyc(1, pat[i], 0, 0);
    chk("s3.kept", 32'(po[0]), 32'hC);
    chk("s3.ovr", 32'(ov[0]), 32'd1);
    chk("s3.ovr_lsb", 32'(ov[1]), 32'd1);
    cyc(0, 0, 0, 1);
    chk("s3.pv_consumed", 32'(pv[0]), 32'd0);
    chk("s3.ovr_sticky", 32'(ov[0]), 32'd1);
    cyc(0, 0, 1, 0);
    chk("s3.ovr_sync", 32'(ov[0]), 32'd0);

    // A completion and a consume on the same edge.
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    chk("s4.full", 32'(po[0]), 32'hF);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 1);
    chk("s4.pv", 32'(pv[0]), 32'd1);
    chk("s4.word", 32'(po[0]), 32'h1);
    chk("s4.word_lsb", 32'(po[1]), 32'h8);
    chk("s4.ovr", 32'(ov[0]), 32'd0);

    // Sync in the middle of a frame, with a bit on the same edge.
    cyc(1, 1, 0, 1); cyc(1, 1, 0, 1);
    cyc(1, 0, 1, 1);
    chk("s5.cnt_sync", 32'(bc[0]), 32'd1);
    cyc(1, 1, 0, 1); cyc(1, 0, 0, 1); cyc(1, 1, 0, 1);
    chk("s5.word", 32'(po[0]), 32'h5);
    chk("s5.word_lsb", 32'(po[1]), 32'hA);
    chk("s5.pv", 32'(pv[0]), 32'd1);

    // Asynchronous reset after 2 bits of a frame.
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    reset = 1'b0; #1;
    for (int m = 0; m < 2; m++) begin
      chk("ar.par_out", 32'(po[m]), 32'h0);
      chk("ar.par_valid", 32'(pv[m]), 32'h0);
      chk("ar.bit_cnt", 32'(bc[m]), 32'h0);
      chk("ar.busy", 32'(bz[m]), 32'h0);
      chk("ar.overrun", 32'(ov[m]), 32'h0);
    end
    @(posedge clk); #1 reset = 1'b1;

    // Randomized traffic, with occasional sync pulses and resets.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 400) == 0) begin
        reset = 1'b0;
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
        reset = 1'b1;
      end
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 50) == 0), 1'($urandom_range(0, 2) == 0));
    end

    cyc(0, 0, 0, 0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
